// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and parameter derivation helpers
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int calc_nstep(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int nstep);
        return $clog2(nstep + 1);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder exposing the carry into its top bit
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = ((x[i] ^ y[i]) & c[i]) | (x[i] & y[i]);
    end

    assign co    = c[DIGIT];
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock LSB first, valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
    localparam int CW    = calc_cnt_w(NSTEP);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT must divide WIDTH");
    end

    state_t                 state;
    logic [WIDTH-1:0]       ar;
    logic [WIDTH-1:0]       br;
    logic [CW-1:0]          step;
    logic                   carry;
    logic [DIGIT-1:0]       s;
    logic                   co;
    logic                   c_top;
    logic [WIDTH+DIGIT-1:0] shifted;

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .x     (ar[DIGIT-1:0]),
        .y     (br[DIGIT-1:0]),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_top (c_top)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    // new digit enters at the MSB end; after NSTEP steps the first digit sits at the LSB
    assign shifted   = {s, sum};

    // FSM with operand/result shift registers; subtract is a + ~b + 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ar    <= a;
                    br    <= sub ? ~b : b;
                    carry <= sub ? 1'b1 : cin;
                    step  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum   <= shifted[WIDTH+DIGIT-1:DIGIT];
                    ar    <= ar >> DIGIT;
                    br    <= br >> DIGIT;
                    carry <= co;
                    step  <= step + 1'b1;
                    if (step == LAST) begin
                        state <= DONE;
                        cout  <= co;
                        ovf   <= co ^ c_top;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
